// File: rtl/arbiter_round_robin_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arbiter_round_robin_if : request/grant bundle, three requesters    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface arbiter_round_robin_if;
  logic req0;
  logic req1;
  logic req2;
  logic gnt0;
  logic gnt1;
  logic gnt2;

  modport master (output req0, req1, req2, input gnt0, gnt1, gnt2);
  modport slave  (input req0, req1, req2, output gnt0, gnt1, gnt2);
endinterface
`default_nettype wire

// File: rtl/arbiter_round_robin.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arbiter_round_robin : 3-way locking round-robin arbiter, one-hot   |
// | registered grants. rev 1.0                                         |
// +--------------------------------------------------------------------+
module arbiter_round_robin (
  input  logic                  clk,
  input  logic                  rst,
  arbiter_round_robin_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    GNT2 = 2'd3
  } state_t;

  localparam logic [1:0] LAST_RESET = 2'd2;

  state_t     state;
  state_t     nxt_state;
  logic [1:0] last;
  logic [1:0] nxt_last;
  logic [1:0] owner;
  logic [1:0] base;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [2:0] req;
  logic [2:0] gnt;

  assign req = {bus.req2, bus.req1, bus.req0};

  function automatic logic [1:0] succ(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic requesting(input logic [2:0] r, input logic [1:0] i);
    case (i)
      2'd0:    return r[0];
      2'd1:    return r[1];
      2'd2:    return r[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic state_t grant_of(input logic [1:0] i);
    return state_t'(i + 2'd1);
  endfunction

  // Search always starts just after the current owner, or after `last` when idle.
  always_comb begin
    nxt_state = state;
    nxt_last  = last;
    owner     = state - 2'd1;
    base      = (state == IDLE) ? last : owner;
    cand1     = succ(base);
    cand2     = succ(cand1);
    if (state == IDLE) begin
      if (requesting(req, cand1)) begin
        nxt_state = grant_of(cand1);
        nxt_last  = cand1;
      end else if (requesting(req, cand2)) begin
        nxt_state = grant_of(cand2);
        nxt_last  = cand2;
      end else if (requesting(req, last)) begin
        nxt_state = grant_of(last);
      end
    end else if (!requesting(req, owner)) begin
      if (requesting(req, cand1)) begin
        nxt_state = grant_of(cand1);
        nxt_last  = cand1;
      end else if (requesting(req, cand2)) begin
        nxt_state = grant_of(cand2);
        nxt_last  = cand2;
      end else begin
        nxt_state = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      last  <= LAST_RESET;
      gnt   <= 3'b000;
    end else begin
      state <= nxt_state;
      last  <= nxt_last;
      gnt   <= {nxt_state == GNT2, nxt_state == GNT1, nxt_state == GNT0};
    end
  end

  assign bus.gnt0 = gnt[0];
  assign bus.gnt1 = gnt[1];
  assign bus.gnt2 = gnt[2];

endmodule
`default_nettype wire

// File: tb/tb_arbiter_round_robin.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_arbiter_round_robin : scoreboard bench for arbiter_round_robin  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_arbiter_round_robin;

  logic clk = 1'b0;
  logic rst = 1'b0;
  arbiter_round_robin_if bus ();

  arbiter_round_robin dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [2:0] gnt;
  assign gnt = {bus.gnt2, bus.gnt1, bus.gnt0};

  int tests = 0;
  int fails = 0;
  logic [2:0] sb [$];
  int m_owner = -1;
  int m_ptr   = 2;

  // Reference behaviour: owner keeps grant while requesting, else hand over
  // searching forward from the owner (or from the pointer when idle).
  task automatic drive_cycle(input logic rst_v, input logic [2:0] r);
    int start;
    int span;
    int idx;
    logic [2:0] e;
    @(negedge clk);
    rst = rst_v;
    bus.req0 = r[0];
    bus.req1 = r[1];
    bus.req2 = r[2];
    if (!rst_v) begin
      m_owner = -1;
      m_ptr   = 2;
    end else if (!(m_owner >= 0 && r[m_owner])) begin
      start = (m_owner >= 0) ? m_owner : m_ptr;
      span  = (m_owner >= 0) ? 2 : 3;
      m_owner = -1;
      for (int j = 1; j <= span; j++) begin
        idx = (start + j) % 3;
        if (m_owner < 0 && r[idx]) begin
          m_owner = idx;
          m_ptr   = idx;
        end
      end
    end
    e = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    for (int i = 0; i < 7; i++) begin
      drive_cycle(i >= 5, 3'b000);
      exp = sb.pop_front();
      tests++;
      if (gnt !== exp || gnt !== 3'b000) begin
        fails++;
        $display("FAIL reset cyc%0d gnt=%b expected=%b", i, gnt, 3'b000);
      end
    end
  endtask

  task automatic test_single();
    logic [2:0] rq   [4] = '{3'b001, 3'b001, 3'b000, 3'b000};
    logic [2:0] hand [4] = '{3'b001, 3'b001, 3'b000, 3'b000};
    logic [2:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, rq[i]);
      exp = sb.pop_front();
      tests++;
      if (gnt !== exp || gnt !== hand[i]) begin
        fails++;
        $display("FAIL single cyc%0d gnt=%b model=%b hand=%b", i, gnt, exp, hand[i]);
      end
    end
  endtask

  task automatic test_lock_handover();
    logic [2:0] rq   [6] = '{3'b001, 3'b011, 3'b011, 3'b010, 3'b010, 3'b000};
    logic [2:0] hand [6] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b000};
    logic [2:0] exp;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, rq[i]);
      exp = sb.pop_front();
      tests++;
      if (gnt !== exp || gnt !== hand[i]) begin
        fails++;
        $display("FAIL lock cyc%0d gnt=%b model=%b hand=%b", i, gnt, exp, hand[i]);
      end
    end
  endtask

  // Pointer is 1 here; all rise together, then each owner drops for one cycle.
  task automatic test_rotation_release();
    logic [2:0] rq   [7] = '{3'b111, 3'b011, 3'b110, 3'b101, 3'b100, 3'b000, 3'b011};
    logic [2:0] hand [7] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b000, 3'b001};
    logic [2:0] exp;
    for (int i = 0; i < 7; i++) begin
      drive_cycle(1'b1, rq[i]);
      exp = sb.pop_front();
      tests++;
      if (gnt !== exp || gnt !== hand[i]) begin
        fails++;
        $display("FAIL rotation cyc%0d gnt=%b model=%b hand=%b", i, gnt, exp, hand[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic       rs   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] rq   [6] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b110, 3'b000};
    logic [2:0] hand [6] = '{3'b000, 3'b010, 3'b010, 3'b000, 3'b010, 3'b000};
    logic [2:0] exp;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(rs[i], rq[i]);
      exp = sb.pop_front();
      tests++;
      if (gnt !== exp || gnt !== hand[i]) begin
        fails++;
        $display("FAIL reset_mid cyc%0d gnt=%b model=%b hand=%b", i, gnt, exp, hand[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    logic       rs;
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 40) != 0);
      drive_cycle(rs, 3'($urandom_range(0, 7)));
      exp = sb.pop_front();
      tests++;
      if (gnt !== exp || $countones(gnt) > 1) begin
        fails++;
        $display("FAIL random cyc%0d gnt=%b model=%b", i, gnt, exp);
      end
    end
  endtask

  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.req2 = 1'b0;
    test_reset();
    test_single();
    test_lock_handover();
    test_rotation_release();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arbiter_round_robin.md
# arbiter_round_robin

Three-requester round-robin arbiter with registered, one-hot grants. A requester holds its grant for as long as it keeps its request asserted. When the owner releases, the grant passes to the next pending requester in rotating order. The block sits between three bus masters and one shared resource and guarantees mutual exclusion and starvation-free access.

## Interface
- No parameters. Requester count is fixed at 3.
- clk   input  1  Single clock. All state updates on its rising edge.
- rst   input  1  Reset, synchronous, active-low: when rst is low at a rising clk edge, the block resets.
- req0  input  1  Request from requester 0. Level-sensitive, high = requesting.
- req1  input  1  Request from requester 1.
- req2  input  1  Request from requester 2.
- gnt0  output 1  Grant to requester 0. Registered.
- gnt1  output 1  Grant to requester 1. Registered.
- gnt2  output 1  Grant to requester 2. Registered.

## Operation
- State machine has four states: IDLE, GNT0, GNT1, GNT2.
  - Outputs decode directly from state: gntK = 1 only in GNTK.
  - Grants are one-hot or all-zero. Two grants are never high together.
- Internal 2-bit pointer `last` records the most recently granted requester (values 0..2).
- Priority order from pointer p: (p+1) mod 3, then (p+2) mod 3, then p.
- IDLE:
  - Any req high: go to GNT of the highest-priority requesting index under `last`, and update `last` to that index.
  - No req high: stay in IDLE.
- GNTk with reqk high: stay in GNTk. The grant is locked and other requests are ignored.
- GNTk with reqk low (release):
  - Search (k+1) mod 3, then (k+2) mod 3.
  - First requester found: move directly to its GNT state, with no idle cycle, and update `last`.
  - None found: go to IDLE, leaving `last` = k.
- Simultaneous requests resolve purely by pointer order, never by fixed index priority, except immediately after reset.
- The pointer wraps from 2 to 0.
- A request that rises and falls between two clock edges is never seen.

## Timing
- Reset state (rst low at an edge): state = IDLE, all gnt = 0, `last` = 2. Priority after reset is therefore 0 > 1 > 2.
- Reset mid-grant: grants drop to 0 at that same edge, regardless of req.
- Reset dominates all other inputs.
- Grant latency is 1 cycle. A req first sampled high at edge N, in IDLE, yields gnt high after edge N.
- Release latency is 1 cycle. reqk sampled low at edge N yields gntk low after edge N.
  - The next owner's grant rises after that same edge N. Handover gap is zero cycles.
- An owner may deassert and reassert req. If req is low at any sampled edge, ownership is lost and the requester re-queues behind the others.
- No combinational path from inputs to outputs.

## Test plan
- Reset and idle:
  - Hold rst=0 for 5 cycles with reqs=000 -> gnt=000 throughout.
  - Release reset with reqs still 000 -> gnt stays 000.
- Single requester:
  - req0=1 for 2 cycles, then 0 -> gnt0 high for exactly 2 cycles, starting 1 cycle after req0 rises.
  - Then state returns to IDLE and gnt=000.
- Lock and handover:
  - req0=1 and req1=1 -> gnt0 holds while req0=1.
  - req0 drops -> gnt1 rises the next edge, with no gap.
- Rotation fairness:
  - With `last`=1 and all three requests rising simultaneously from IDLE -> gnt2 first.
  - Each owner drops its req for 1 cycle after its grant -> order 2, 0, 1.
- Release with no contenders:
  - gnt2 owner drops req2 with no other req -> gnt=000 next edge.
  - Then req0 and req1 rise together -> gnt0 (pointer 2 -> 0).
- Reset mid-operation:
  - Assert rst=0 while gnt1 is high and req1=1 -> gnt=000 after that edge.
  - After release with req1 and req2 high -> gnt1 granted (priority 0 > 1 > 2 restored).
